// File: rtl/traffic_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module : traffic_sensor_conditioner
// Desc   : Loop-detector front end: per-road sync, debounce, hold-extend and
//          vehicle count, plus a starvation guard on contested greens.
// Rev    : 1.0
// ============================================================================
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int MAX_GREEN       = 64,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_a,
  input  logic             raw_b,
  input  logic [1:0]       la,
  input  logic [1:0]       lb,
  input  logic             cnt_clr,
  output logic             ta,
  output logic             tb,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             force_a,
  output logic             force_b
);

  localparam int c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int c_GT_W   = (MAX_GREEN > 1) ? $clog2(MAX_GREEN) : 1;

  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(HOLD_CYCLES);
  localparam logic [c_GT_W-1:0]   c_GT_LAST   = c_GT_W'(MAX_GREEN - 1);
  localparam logic [1:0]          c_GREEN     = 2'b00;

  logic [1:0]       w_raw;
  logic [1:0]       w_req;
  logic [1:0]       w_force;
  logic [1:0]       w_light [2];
  logic [CNT_W-1:0] w_cnt   [2];
  logic             w_both_req;

  assign w_raw      = {raw_b, raw_a};
  assign w_light[0] = la;
  assign w_light[1] = lb;
  assign w_both_req = w_req[0] & w_req[1];

  // Index 0 is road A, index 1 is road B; the guard of each road looks at
  // its own light but at both requests.
  for (genvar i = 0; i < 2; i++) begin : g_road
    logic [1:0]          r_sync;
    logic                r_deb;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_GT_W-1:0]   r_gt;
    logic                r_force;
    logic                w_settle;
    logic                w_rise;
    logic                w_fall;

    assign w_settle = (r_sync[1] != r_deb) && (r_db_cnt == c_DB_LAST);
    assign w_rise   = w_settle &  r_sync[1];
    assign w_fall   = w_settle & ~r_sync[1];

    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync   <= '0;
        r_deb    <= 1'b0;
        r_db_cnt <= '0;
        r_hold   <= '0;
        r_cnt    <= '0;
        r_gt     <= '0;
        r_force  <= 1'b0;
      end else begin
        r_sync <= {r_sync[0], w_raw[i]};

        if (r_sync[1] == r_deb) begin
          r_db_cnt <= '0;
        end else if (w_settle) begin
          r_deb    <= r_sync[1];
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end

        if (w_rise) begin
          r_hold <= '0;
        end else if (w_fall) begin
          r_hold <= c_HOLD_INIT;
        end else if (r_hold != '0) begin
          r_hold <= r_hold - 1'b1;
        end

        // Clear beats a coincident rise.
        if (cnt_clr) begin
          r_cnt <= '0;
        end else if (w_rise && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 1'b1;
        end

        // Timer parks at its last value once the guard fires; only leaving
        // green releases it.
        if (w_light[i] != c_GREEN) begin
          r_gt    <= '0;
          r_force <= 1'b0;
        end else if (w_both_req) begin
          if (r_gt == c_GT_LAST) begin
            r_force <= 1'b1;
          end else begin
            r_gt <= r_gt + 1'b1;
          end
        end
      end
    end

    assign w_req[i]   = r_deb | (r_hold != '0);
    assign w_force[i] = r_force;
    assign w_cnt[i]   = r_cnt;
  end

  assign ta      = w_req[0] & ~w_force[0];
  assign tb      = w_req[1] & ~w_force[1];
  assign force_a = w_force[0];
  assign force_b = w_force[1];
  assign cnt_a   = w_cnt[0];
  assign cnt_b   = w_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_traffic_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module : tb_traffic_sensor_conditioner
// Desc   : Directed scenarios then random traffic, compared every cycle
//          against a window/age based reference model.
// Rev    : 1.0
// ============================================================================
module tb_traffic_sensor_conditioner;

  localparam int D    = 4;
  localparam int H    = 8;
  localparam int MG   = 64;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          raw_a;
  logic          raw_b;
  logic [1:0]    la;
  logic [1:0]    lb;
  logic          cnt_clr;
  logic          ta;
  logic          tb;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic          force_a;
  logic          force_b;

  int errors = 0;
  int checks = 0;

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .MAX_GREEN      (MG),
    .CNT_W          (CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .la     (la),
    .lb     (lb),
    .cnt_clr(cnt_clr),
    .ta     (ta),
    .tb     (tb),
    .cnt_a  (cnt_a),
    .cnt_b  (cnt_b),
    .force_a(force_a),
    .force_b(force_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: synced value is raw delayed two edges; the debounced level
  // flips once the last D synced samples all disagree with it; the request
  // stays up while fewer than H edges have passed since the debounced fall.
  int          m_p1    [2];
  int          m_s     [2];
  int          m_deb   [2];
  int unsigned m_win   [2];
  int          m_wlen  [2];
  int          m_since [2];
  int          m_cnt   [2];
  int          m_gt    [2];
  int          m_force [2];

  function automatic int mreq(input int i);
    return ((m_deb[i] != 0) || (m_since[i] < H)) ? 1 : 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_p1[i] = 0; m_s[i] = 0; m_deb[i] = 0; m_win[i] = 0; m_wlen[i] = 0;
      m_since[i] = H; m_cnt[i] = 0; m_gt[i] = 0; m_force[i] = 0;
    end
  endtask

  task automatic model_step();
    int r0, r1;
    int raw [2];
    int grn [2];
    raw[0] = raw_a ? 1 : 0;
    raw[1] = raw_b ? 1 : 0;
    grn[0] = (la == 2'b00) ? 1 : 0;
    grn[1] = (lb == 2'b00) ? 1 : 0;
    if (reset) begin
      model_clear();
      return;
    end
    r0 = mreq(0);
    r1 = mreq(1);
    for (int i = 0; i < 2; i++) begin
      int unsigned mask;
      int flip;
      mask = (32'd1 << D) - 1;
      m_win[i]  = (m_win[i] << 1) | m_s[i];
      m_wlen[i] = (m_wlen[i] < 32) ? m_wlen[i] + 1 : 32;
      flip = (m_wlen[i] >= D) &&
             ((m_win[i] & mask) == ((m_deb[i] != 0) ? 0 : mask));
      if (flip != 0) begin
        if (m_deb[i] == 0) begin
          m_since[i] = H;
          if (m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
        end else begin
          m_since[i] = 0;
        end
        m_deb[i] = (m_deb[i] == 0) ? 1 : 0;
      end else if (m_since[i] < H) begin
        m_since[i] = m_since[i] + 1;
      end
      if (cnt_clr) m_cnt[i] = 0;
      if (grn[i] == 0) begin
        m_gt[i] = 0;
        m_force[i] = 0;
      end else if ((r0 != 0) && (r1 != 0)) begin
        if (m_gt[i] + 1 >= MG) m_force[i] = 1;
        m_gt[i] = (m_gt[i] < MG) ? m_gt[i] + 1 : MG;
      end
      m_s[i]  = m_p1[i];
      m_p1[i] = raw[i];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ta",      32'(ta),      32'((mreq(0) != 0) && (m_force[0] == 0)));
    chk("tb",      32'(tb),      32'((mreq(1) != 0) && (m_force[1] == 0)));
    chk("cnt_a",   32'(cnt_a),   32'(m_cnt[0]));
    chk("cnt_b",   32'(cnt_b),   32'(m_cnt[1]));
    chk("force_a", 32'(force_a), 32'(m_force[0]));
    chk("force_b", 32'(force_b), 32'(m_force[1]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    model_clear();
    reset = 1'b1; raw_a = 1'b0; raw_b = 1'b0;
    la = 2'b10; lb = 2'b10; cnt_clr = 1'b0;

    // Reset state
    ticks(3);
    chk("rst_ta", 32'(ta), 0);
    chk("rst_tb", 32'(tb), 0);
    chk("rst_cnt_a", 32'(cnt_a), 0);
    chk("rst_force_a", 32'(force_a), 0);
    reset = 1'b0;
    ticks(2);

    // Rise latency: raw set before edge 0, ta up after edge 5
    raw_a = 1'b1;
    ticks(5);
    chk("lat_ta_lo", 32'(ta), 0);
    tick();
    chk("lat_ta_hi", 32'(ta), 1);
    chk("lat_cnt_a", 32'(cnt_a), 1);
    chk("lat_tb", 32'(tb), 0);
    ticks(4);

    // Three-cycle glitch low is ignored
    raw_a = 1'b0;
    ticks(3);
    raw_a = 1'b1;
    ticks(10);
    chk("glitch_ta", 32'(ta), 1);
    chk("glitch_cnt_a", 32'(cnt_a), 1);

    // Debounced fall after edge 5, ta falls 8 edges later
    raw_a = 1'b0;
    ticks(13);
    chk("hold_ta_last", 32'(ta), 1);
    tick();
    chk("hold_ta_fall", 32'(ta), 0);

    // Re-assert inside the hold window: no drop, count increments
    raw_a = 1'b1;
    ticks(10);
    raw_a = 1'b0;
    ticks(6);
    raw_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rehold_ta", 32'(ta), 1);
    end
    chk("rehold_cnt_a", 32'(cnt_a), 3);

    // Starvation guard on road A
    raw_b = 1'b1;
    ticks(8);
    la = 2'b00;
    ticks(63);
    chk("guard_force_pre", 32'(force_a), 0);
    tick();
    chk("guard_force_a", 32'(force_a), 1);
    chk("guard_ta", 32'(ta), 0);
    chk("guard_force_b", 32'(force_b), 0);
    la = 2'b01;
    tick();
    chk("guard_release", 32'(force_a), 0);
    chk("guard_ta_back", 32'(ta), 1);
    la = 2'b10;

    // Saturating count on road B
    for (int p = 0; p < 300; p++) begin
      raw_b = 1'b0; ticks(6);
      raw_b = 1'b1; ticks(6);
    end
    chk("sat_cnt_b", 32'(cnt_b), CMAX);
    raw_b = 1'b0; ticks(6);
    raw_b = 1'b1; ticks(5);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_wins", 32'(cnt_b), 0);
    raw_b = 1'b0; ticks(6);
    raw_b = 1'b1; ticks(6);
    chk("clr_next_rise", 32'(cnt_b), 1);

    // Reset mid-hold with ta=1 and force_b=1
    lb = 2'b00;
    ticks(70);
    raw_a = 1'b0;
    ticks(8);
    chk("mid_ta_held", 32'(ta), 1);
    chk("mid_force_b", 32'(force_b), 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_ta", 32'(ta), 0);
    chk("mid_rst_tb", 32'(tb), 0);
    chk("mid_rst_force_b", 32'(force_b), 0);
    chk("mid_rst_cnt_b", 32'(cnt_b), 0);
    reset = 1'b0; raw_a = 1'b1; lb = 2'b10;
    ticks(5);
    chk("reacq_ta_lo", 32'(ta), 0);
    tick();
    chk("reacq_ta_hi", 32'(ta), 1);

    // Random traffic, lights and occasional clears/resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7) == 0) raw_a = ~raw_a;
      if ($urandom_range(7) == 0) raw_b = ~raw_b;
      if ($urandom_range(47) == 0) la = 2'($urandom_range(2));
      if ($urandom_range(47) == 0) lb = 2'($urandom_range(2));
      cnt_clr = ($urandom_range(149) == 0);
      reset   = ($urandom_range(699) == 0);
      tick();
    end
    reset = 1'b0; cnt_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
